ac97_frame_tx: RTL and testbench
================================

Name: ac97_frame_tx

Overview:
- AC'97 output-frame serializer on the codec-supplied BIT_CLK.
- Generates SYNC and SDATA_OUT for 256-bit frames.
- Carries PCM left/right samples from the waveform generators (slots 3/4) and one optional codec register command per frame (slots 1/2).
- Emits the one-cycle per-frame pulse FRAME_SIG that the waveform generators use to advance.

Parameters:
SAMPLE_W, 18, PCM sample width (1..20). Samples are left-justified into 20-bit slots; unused LSBs are zero.

Ports:
BIT_CLK  input  1  AC'97 bit clock (12.288 MHz). All logic on its rising edge.
RESET  input  1  synchronous, active-high reset
L_SAMPLE  input  SAMPLE_W  left PCM sample, two's complement
R_SAMPLE  input  SAMPLE_W  right PCM sample
CMD_VALID  input  1  command request
CMD_READY  output  1  command slot free (= !pending)
CMD_RW  input  1  1 = register read, 0 = write
CMD_ADDR  input  7  codec register index
CMD_DATA  input  16  write data
SYNC  output  1  AC'97 frame sync
SDATA_OUT  output  1  serial data to codec, MSB first
FRAME_SIG  output  1  one-cycle pulse per frame

Behaviour:
Counter and outputs
- Internal 8-bit counter BIT_COUNT (0..255), wraps 255 -> 0.
- At each rising edge with count n: SDATA_OUT and SYNC are loaded with the values for frame bit n, and the counter goes to (n+1) mod 256.
- All outputs are registered.

Reset
- BIT_COUNT=0, SYNC=0, SDATA_OUT=0, FRAME_SIG=0.
- Pending command cleared; CMD_READY=1.
- Shadow samples = 0; shadow command invalid.
- Reset mid-frame aborts the frame immediately.
- The first edge after RESET falls loads frame bit 0.

SYNC
- Loaded 1 for frame bits 0..15, else 0.
- Result: high for exactly 16 BIT_CLK cycles per 256.

Frame layout (frame bit index n)
- Slot 0 tag, bits 0..15: bit n carries tag[15-n].
  - tag[15] = 1.
  - tag[14] = tag[13] = shadow command valid.
  - tag[12] = tag[11] = 1.
  - tag[10:0] = 0.
- Slot k (1..12) occupies bits 16+20(k-1) .. 35+20(k-1), MSB first.
- Slot 1 (bits 16..35): {CMD_RW, CMD_ADDR, 12'b0} from shadow; all zero if shadow command invalid.
- Slot 2 (bits 36..55): {CMD_DATA, 4'b0} from shadow if CMD_RW=0; zero if read or invalid.
- Slot 3 (bits 56..75): {shadow L, (20-SAMPLE_W) zeros}.
- Slot 4 (bits 76..95): {shadow R, zeros}.
- Slots 5..12 (bits 96..255): 0.

Frame boundary (edge where BIT_COUNT==255)
- Shadow L/R <= L_SAMPLE/R_SAMPLE.
- FRAME_SIG <= 1 for exactly one cycle; it is 0 on all other edges.
- Generators advance on FRAME_SIG, so their next value is sampled one frame later.
- Shadow command valid <= pending OR (CMD_VALID AND CMD_READY).
  - Shadow fields come from the pending register if pending, else directly from the inputs.
  - Pending is cleared, so CMD_READY reads 1 in the next cycle.
- Inputs are sampled only at this edge; changes mid-frame never corrupt the frame in flight.

Command handshake
- CMD_VALID AND CMD_READY at any edge other than count 255: fields captured into the pending register; pending <= 1; CMD_READY = 0 from the next cycle.
- Case VALID&&READY at count 255 is covered under Frame boundary.
- At most one command per frame.
- Holding CMD_VALID without READY has no effect.
- Pending survives until the boundary; only RESET discards it.
- Latency: a command accepted during frame F is transmitted in frame F+1.

Test Plan:
- Reset release, no commands, L=R=0 for 2 frames -> SYNC high 16 cycles per 256; tag bits = 16'h9800 each frame; all other bits 0; FRAME_SIG pulses exactly 256 cycles apart.
- L=18'h3FFFF, R=18'h20001 held -> slot 3 = 20'hFFFFC, slot 4 = 20'h80004, in frames following the first boundary after values were applied.
- Write CMD_ADDR=7'h02, CMD_DATA=16'h0808 accepted mid-frame -> CMD_READY low until next boundary. Next frame: tag = 16'hF800, slot 1 = 20'h02000, slot 2 = 20'h08080. Following frame: tag back to 16'h9800.
- Read CMD_RW=1, CMD_ADDR=7'h7C presented with VALID exactly at BIT_COUNT==255 -> sent in the immediately following frame; slot 1 = 20'hFC000, slot 2 = 0, tag = 16'hF800.
- Second CMD_VALID held while pending -> not accepted until CMD_READY returns; then sent one frame later; no frame carries two commands.
- RESET asserted at BIT_COUNT==100 with a command pending -> outputs 0 next cycle; pending dropped; restart at frame bit 0; first frame tag = 16'h9800.

Source files
------------

// File: rtl/ac97_frame_tx.sv
// AC'97 output-frame serializer: builds 256-bit frames (tag, command, PCM L/R)
// and shifts them out MSB first on BIT_CLK, with a one-cycle FRAME_SIG per frame.
module ac97_frame_tx #(
  parameter int SAMPLE_W = 18
) (
  input  logic                BIT_CLK,
  input  logic                RESET,
  input  logic [SAMPLE_W-1:0] L_SAMPLE,
  input  logic [SAMPLE_W-1:0] R_SAMPLE,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_RW,
  input  logic [6:0]          CMD_ADDR,
  input  logic [15:0]         CMD_DATA,
  output logic                SYNC,
  output logic                SDATA_OUT,
  output logic                FRAME_SIG
);

  logic [7:0]          bit_count;
  logic                boundary;

  logic                pend;
  logic                pend_rw;
  logic [6:0]          pend_addr;
  logic [15:0]         pend_data;

  logic                sh_valid;
  logic                sh_rw;
  logic [6:0]          sh_addr;
  logic [15:0]         sh_data;
  logic [SAMPLE_W-1:0] sh_l;
  logic [SAMPLE_W-1:0] sh_r;

  logic                sync_q;
  logic                sdata_q;
  logic                frame_q;

  logic [15:0]         tag;
  logic [19:0]         slot1;
  logic [19:0]         slot2;
  logic [19:0]         slot3;
  logic [19:0]         slot4;
  logic                next_bit;

  assign boundary  = (bit_count == 8'd255);

  // Handshake: a command transfers on any edge where CMD_VALID && CMD_READY.
  // CMD_READY is simply !pend, so at most one command waits per frame.
  assign CMD_READY = !pend;

  assign SYNC      = sync_q;
  assign SDATA_OUT = sdata_q;
  assign FRAME_SIG = frame_q;

  always_comb begin
    tag   = {1'b1, sh_valid, sh_valid, 2'b11, 11'b0};
    slot1 = sh_valid ? {sh_rw, sh_addr, 12'b0} : 20'b0;
    slot2 = (sh_valid && !sh_rw) ? {sh_data, 4'b0} : 20'b0;
    slot3 = 20'(sh_l) << (20 - SAMPLE_W);
    slot4 = 20'(sh_r) << (20 - SAMPLE_W);
    next_bit = 1'b0;
    // Each slot is sent MSB first, so the bit index counts down from the slot's last bit.
    if (bit_count < 8'd16)      next_bit = tag[4'(8'd15 - bit_count)];
    else if (bit_count < 8'd36) next_bit = slot1[5'(8'd35 - bit_count)];
    else if (bit_count < 8'd56) next_bit = slot2[5'(8'd55 - bit_count)];
    else if (bit_count < 8'd76) next_bit = slot3[5'(8'd75 - bit_count)];
    else if (bit_count < 8'd96) next_bit = slot4[5'(8'd95 - bit_count)];
  end

  always_ff @(posedge BIT_CLK) begin
    if (RESET) begin
      bit_count <= 8'd0;
      sync_q    <= 1'b0;
      sdata_q   <= 1'b0;
      frame_q   <= 1'b0;
      pend      <= 1'b0;
      pend_rw   <= 1'b0;
      pend_addr <= 7'd0;
      pend_data <= 16'd0;
      sh_valid  <= 1'b0;
      sh_rw     <= 1'b0;
      sh_addr   <= 7'd0;
      sh_data   <= 16'd0;
      sh_l      <= '0;
      sh_r      <= '0;
    end else begin
      bit_count <= bit_count + 8'd1;
      sync_q    <= (bit_count < 8'd16);
      sdata_q   <= next_bit;
      frame_q   <= boundary;
      if (boundary) begin
        // Shadow registers freeze everything the next frame transmits.
        sh_l     <= L_SAMPLE;
        sh_r     <= R_SAMPLE;
        sh_valid <= pend | (CMD_VALID & CMD_READY);
        sh_rw    <= pend ? pend_rw   : CMD_RW;
        sh_addr  <= pend ? pend_addr : CMD_ADDR;
        sh_data  <= pend ? pend_data : CMD_DATA;
        pend     <= 1'b0;
      end else if (CMD_VALID && CMD_READY) begin
        pend      <= 1'b1;
        pend_rw   <= CMD_RW;
        pend_addr <= CMD_ADDR;
        pend_data <= CMD_DATA;
      end
    end
  end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Self-checking bench for ac97_frame_tx: frame-level reference model, per-cycle
// compare, directed frame captures against literal slot values, random traffic.
module tb_ac97_frame_tx;
  localparam int SW = 18;

  logic          clk;
  logic          reset;
  logic [SW-1:0] l_sample;
  logic [SW-1:0] r_sample;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [6:0]    cmd_addr;
  logic [15:0]   cmd_data;
  logic          sync;
  logic          sdata_out;
  logic          frame_sig;

  ac97_frame_tx #(.SAMPLE_W(SW)) dut (
    .BIT_CLK(clk), .RESET(reset), .L_SAMPLE(l_sample), .R_SAMPLE(r_sample),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_RW(cmd_rw),
    .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .SYNC(sync),
    .SDATA_OUT(sdata_out), .FRAME_SIG(frame_sig)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a whole frame is one 256-bit word, frame bit n = word[255-n].
  function automatic logic [255:0] build_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                                               input logic v, input logic rw,
                                               input logic [6:0] a, input logic [15:0] d);
    logic [15:0] t;
    logic [19:0] s1, s2, s3, s4;
    t  = {1'b1, v, v, 2'b11, 11'b0};
    s1 = v ? {rw, a, 12'b0} : 20'b0;
    s2 = (v && !rw) ? {d, 4'b0} : 20'b0;
    s3 = {l, {(20-SW){1'b0}}};
    s4 = {r, {(20-SW){1'b0}}};
    return {t, s1, s2, s3, s4, 160'b0};
  endfunction

  logic [255:0] exp_q[$];
  logic [255:0] cur_frame;
  int           m_cnt = 0;
  bit           m_init = 0;
  bit           m_pend = 0;
  logic         p_rw;
  logic [6:0]   p_addr;
  logic [15:0]  p_data;
  logic         e_sync, e_sdata, e_fs, e_ready;
  bit           fs_have = 0;
  int           fs_last = 0;
  int           cyc = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1;
      m_cnt  = 0;
      m_pend = 0;
      exp_q.delete();
      cur_frame = build_frame('0, '0, 1'b0, 1'b0, 7'd0, 16'd0);
      e_sync = 0; e_sdata = 0; e_fs = 0;
      fs_have = 0;
    end else if (m_init) begin
      if (m_cnt == 0 && exp_q.size() > 0) cur_frame = exp_q.pop_front();
      e_sdata = cur_frame[255 - m_cnt];
      e_sync  = (m_cnt < 16);
      e_fs    = (m_cnt == 255);
      if (m_cnt == 255) begin
        if (m_pend) exp_q.push_back(build_frame(l_sample, r_sample, 1'b1, p_rw, p_addr, p_data));
        else        exp_q.push_back(build_frame(l_sample, r_sample, cmd_valid, cmd_rw, cmd_addr, cmd_data));
        m_pend = 0;
      end else if (cmd_valid && !m_pend) begin
        m_pend = 1; p_rw = cmd_rw; p_addr = cmd_addr; p_data = cmd_data;
      end
      m_cnt = (m_cnt + 1) % 256;
    end
    e_ready = !m_pend;
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (m_init) begin
      cyc++;
      check("sync", 32'(sync), 32'(e_sync));
      check("sdata_out", 32'(sdata_out), 32'(e_sdata));
      check("frame_sig", 32'(frame_sig), 32'(e_fs));
      check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      if (frame_sig) begin
        if (fs_have) check("frame_sig_spacing", 32'(cyc - fs_last), 32'd256);
        fs_have = 1;
        fs_last = cyc;
      end
    end
  end

  // driver tasks
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_cnt(input int k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (m_cnt == k) begin ok = 1; break; end
    end
    check("wait_count_reached", 32'(ok), 32'd1);
  endtask

  task automatic grab_frame(output logic [255:0] f);
    logic prev;
    bit   found;
    f = '0;
    prev = sync;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (sync && !prev) found = 1;
      prev = sync;
    end
    check("grab_sync_found", 32'(found), 32'd1);
    if (found) begin
      f[255] = sdata_out;
      for (int k = 1; k < 256; k++) begin
        @(negedge clk);
        f[255 - k] = sdata_out;
      end
    end
  endtask

  task automatic check_frame(input string nm, input logic [255:0] f, input logic [15:0] t,
                             input logic [19:0] s1, input logic [19:0] s2,
                             input logic [19:0] s3, input logic [19:0] s4);
    check({nm, "_tag"},   32'(f[255:240]), 32'(t));
    check({nm, "_slot1"}, 32'(f[239:220]), 32'(s1));
    check({nm, "_slot2"}, 32'(f[219:200]), 32'(s2));
    check({nm, "_slot3"}, 32'(f[199:180]), 32'(s3));
    check({nm, "_slot4"}, 32'(f[179:160]), 32'(s4));
    check({nm, "_rest"},  32'(|f[159:0]),  32'd0);
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] a, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
  endtask

  logic [255:0] f, mf;

  initial begin
    reset = 1'b1; l_sample = '0; r_sample = '0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;

    // pin the model with hand-computed words
    mf = build_frame('0, '0, 1'b0, 1'b0, 7'd0, 16'd0);
    check_frame("model_idle", mf, 16'h9800, 20'h0, 20'h0, 20'h0, 20'h0);
    mf = build_frame(18'h3FFFF, 18'h20001, 1'b1, 1'b0, 7'h02, 16'h0808);
    check_frame("model_write", mf, 16'hF800, 20'h02000, 20'h08080, 20'hFFFFC, 20'h80004);
    mf = build_frame('0, '0, 1'b1, 1'b1, 7'h7C, 16'hFFFF);
    check_frame("model_read", mf, 16'hF800, 20'hFC000, 20'h0, 20'h0, 20'h0);

    // reset state and idle frames
    @(negedge clk);
    @(negedge clk);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_sdata", 32'(sdata_out), 32'd0);
    check("rst_frame_sig", 32'(frame_sig), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    do_reset(1);
    grab_frame(f); check_frame("idle0", f, 16'h9800, 0, 0, 0, 0);
    grab_frame(f); check_frame("idle1", f, 16'h9800, 0, 0, 0, 0);

    // samples take effect one boundary later
    l_sample = 18'h3FFFF; r_sample = 18'h20001;
    grab_frame(f); check_frame("pcm_old", f, 16'h9800, 0, 0, 0, 0);
    grab_frame(f); check_frame("pcm_new", f, 16'h9800, 0, 0, 20'hFFFFC, 20'h80004);

    // mid-frame write
    repeat (40) @(negedge clk);
    send_cmd(1'b0, 7'h02, 16'h0808);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("write_ready_low", 32'(cmd_ready), 32'd0);
    grab_frame(f); check_frame("write", f, 16'hF800, 20'h02000, 20'h08080, 20'hFFFFC, 20'h80004);
    grab_frame(f); check_frame("after_write", f, 16'h9800, 0, 0, 20'hFFFFC, 20'h80004);

    // read presented exactly at the boundary
    wait_cnt(255);
    send_cmd(1'b1, 7'h7C, 16'hFFFF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("read_ready_high", 32'(cmd_ready), 32'd1);
    grab_frame(f); check_frame("read", f, 16'hF800, 20'hFC000, 20'h0, 20'hFFFFC, 20'h80004);

    // second command held while the first is pending
    repeat (20) @(negedge clk);
    send_cmd(1'b0, 7'h10, 16'h1234);
    @(negedge clk);
    cmd_addr = 7'h20; cmd_data = 16'h5678;
    check("held_ready_low", 32'(cmd_ready), 32'd0);
    fork
      grab_frame(f);
      begin
        wait_cnt(1);
        cmd_valid = 1'b0;
      end
    join
    check_frame("held_first", f, 16'hF800, 20'h10000, 20'h12340, 20'hFFFFC, 20'h80004);
    grab_frame(f); check_frame("held_second", f, 16'hF800, 20'h20000, 20'h56780, 20'hFFFFC, 20'h80004);

    // reset mid-frame with a command pending
    wait_cnt(50);
    send_cmd(1'b0, 7'h33, 16'hABCD);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_cnt(100);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_sync", 32'(sync), 32'd0);
    check("midrst_sdata", 32'(sdata_out), 32'd0);
    check("midrst_frame_sig", 32'(frame_sig), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    grab_frame(f); check_frame("post_rst", f, 16'h9800, 0, 0, 0, 0);

    // random traffic, model compare only
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        l_sample = SW'($urandom); r_sample = SW'($urandom);
      end
      if (!cmd_valid) begin
        if ($urandom_range(0, 29) == 0)
          send_cmd(1'($urandom), 7'($urandom), 16'($urandom));
      end else begin
        case ($urandom_range(0, 7))
          0: cmd_valid = 1'b0;
          1: send_cmd(1'($urandom), 7'($urandom), 16'($urandom));
          default: ;
        endcase
      end
      reset = (i >= 1500 && i < 1502);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (300) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
